mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Next-generation memory stage of the RISC-V pipeline, sitting between the EX/MEM and MEM/WB registers.
- Executes loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) over a byte-serial RAM port. Each access is split into 1, 2 or 4 beats, and read bytes are assembled little-endian.
- Holds the pipeline with stall_req for the whole access, then presents one completion cycle.
- Adds over the previous stage: stores, flush, and a handshake watchdog with an error pulse.

Parameters:
- ADDR_W, 17, RAM byte-address width.
- REG_ADDR_W, 5, register index width.
- TIMEOUT, 0, max cycles waiting for ram_ack on one beat. 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  EX/MEM holds a valid instruction.
- wd_i  in  REG_ADDR_W  destination register.
- wreg_i  in  1  register-write enable.
- wdata_i  in  32  ALU result (non-memory ops).
- mem_op_i  in  4  {is_mem, is_store, is_unsigned, size[0]}. Size encoding: mem_op_i[0]/mem_addr_i usage below.
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_addr_i  in  ADDR_W  effective byte address.
- mem_data_i  in  32  store data.
- flush_i  in  1  kill in-flight op.
- ram_req_o  out  1  beat request.
- ram_wr_o  out  1  1 = write beat.
- ram_addr_o  out  ADDR_W  beat address.
- ram_wdata_o  out  8  write byte.
- ram_rdata_i  in  8  read byte, valid when ram_ack_i=1.
- ram_ack_i  in  1  beat accepted/completed this cycle.
- wd_o  out  REG_ADDR_W  to MEM/WB.
- wreg_o  out  1  to MEM/WB.
- wdata_o  out  32  to MEM/WB.
- stall_req  out  1  hold all earlier stages.
- err_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; beat_cnt, data_buf and watchdog cleared.
  - All outputs 0: ram_req_o, ram_wr_o, ram_addr_o, ram_wdata_o, wd_o, wreg_o, wdata_o, stall_req, err_o.
  - Reset mid-access abandons the beat with no writeback.
- States: IDLE, ACCESS, DONE.
- IDLE, non-memory op (valid_i=1, is_mem=0):
  - Combinational pass-through: wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i, stall_req=0.
- IDLE, valid_i=0 or size=11 with is_mem=1:
  - Outputs 0.
  - No RAM traffic; the illegal size is treated as a NOP.
- IDLE, valid memory op:
  - stall_req=1 combinationally; move to ACCESS next edge.
  - Latch nbeats = 1/2/4, base address, store data, wd, signedness, load/store.
- ACCESS:
  - ram_req_o=1, ram_addr_o=base+beat_cnt (wraps modulo 2^ADDR_W), ram_wr_o=is_store.
  - ram_wdata_o = store_data[8*beat_cnt+7 : 8*beat_cnt].
  - stall_req=1.
  - On ram_ack_i:
    - Loads capture ram_rdata_i into data_buf byte beat_cnt.
    - beat_cnt increments; on the last beat go to DONE.
  - Without ack the request and address are held unchanged.
- DONE (exactly 1 cycle, then IDLE):
  - stall_req=0, ram_req_o=0.
  - Loads: wd_o=latched wd, wreg_o=1. wdata_o is data_buf extended from 8/16/32 bits: sign-extended unless unsigned. Upper unused bytes are ignored.
  - Stores: wreg_o=0, wdata_o=0.
  - Upstream advances on this edge, so the same op never restarts.
- Watchdog (TIMEOUT>0):
  - Counter increments each ACCESS cycle without ack and clears on ack.
  - When it reaches TIMEOUT: err_o=1 for one cycle, go to IDLE with no writeback, stall_req=0 that cycle.
  - Beats already written by a store are not rolled back.
- flush_i=1 (any state):
  - Next state IDLE, ram_req_o forced 0 that cycle, no writeback.
  - flush wins over ack and timeout in the same cycle.
- Simultaneous ack and timeout count reaching TIMEOUT: ack wins; the beat completes.
- ram_ack_i while not requesting: ignored.

Test Plan:
- LW at 0x00010, RAM bytes 0x78,0x56,0x34,0x12, ack every cycle -> addrs 0x10..0x13, stall_req high 5 cycles, DONE wdata_o=0x12345678, wreg_o=1.
- LB at 0x1FFFF, byte 0x80, then LBU same -> wdata_o 0xFFFFFF80 then 0x00000080. LH at 0x1FFFF -> second beat addr 0x00000 (wrap).
- SH data 0xAABBCCDD at 0x20, ack delayed 3 cycles per beat -> writes 0xDD@0x20, 0xCC@0x21, request held stable while waiting, DONE wreg_o=0.
- ADD result 0x5 to x3, valid_i=1, is_mem=0 -> same-cycle wd_o=3, wdata_o=5, stall_req=0, no ram_req_o.
- TIMEOUT=4, LW with no ack -> err_o pulse on 5th ACCESS cycle, wreg_o=0, back to IDLE. flush_i on beat 2 of LW -> ram_req_o drops, no DONE.
- Assert rst mid-LH after first ack -> all outputs 0 immediately; after release a new LB completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Byte-serial RAM port used by the memory stage.
// master = memory stage (issues beats), slave = RAM side (acks, returns data).
interface mem_access_unit_if #(
  parameter int ADDR_W = 17
);
  logic              ram_req;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic              ram_ack;

  modport master (
    output ram_req,
    output ram_wr,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata,
    input  ram_ack
  );

  modport slave (
    input  ram_req,
    input  ram_wr,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata,
    output ram_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: executes LB/LH/LW/LBU/LHU/SB/SH/SW as 1/2/4 byte beats over a
// byte-serial RAM port, stalling the pipeline for the whole access and then
// presenting a single completion cycle. Supports flush and an optional
// per-beat handshake watchdog that aborts the access with an error pulse.
module mem_access_unit #(
  parameter int ADDR_W     = 17,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [1:0]            mem_size_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           mem_data_i,
  input  logic                  flush_i,
  mem_access_unit_if.master     ram,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stall_req,
  output logic                  err_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // Watchdog counter must be able to hold TIMEOUT itself.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]            state;
  logic [1:0]            beat_cnt;
  logic [1:0]            last_beat;
  logic [ADDR_W-1:0]     base_addr;
  logic [31:0]           store_data;
  logic [31:0]           data_buf;
  logic [REG_ADDR_W-1:0] wd_q;
  logic [1:0]            size_q;
  logic                  is_signed_q;
  logic                  is_store_q;
  logic [WD_W-1:0]       wd_cnt;

  logic                  is_mem;
  logic                  start;
  logic                  timeout_hit;
  logic [31:0]           load_data;

  // Low bit of mem_op_i duplicates size information carried on mem_size_i.
  logic unused_op;
  assign unused_op = mem_op_i[0];

  assign is_mem      = mem_op_i[3];
  assign start       = valid_i && is_mem && (mem_size_i != 2'b11) && !flush_i;
  assign timeout_hit = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT));

  // Index of the final beat for the latched access size.
  always_comb begin
    case (size_q)
      2'b00:   last_beat = 2'd0;
      2'b01:   last_beat = 2'd1;
      default: last_beat = 2'd3;
    endcase
  end

  // Extend the assembled little-endian load data to 32 bits.
  always_comb begin
    case (size_q)
      2'b00:   load_data = {{24{is_signed_q & data_buf[7]}}, data_buf[7:0]};
      2'b01:   load_data = {{16{is_signed_q & data_buf[15]}}, data_buf[15:0]};
      default: load_data = data_buf;
    endcase
  end

  // Access sequencing: latch the op, step through beats, watchdog, flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      base_addr   <= '0;
      store_data  <= '0;
      data_buf    <= '0;
      wd_q        <= '0;
      size_q      <= '0;
      is_signed_q <= 1'b0;
      is_store_q  <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ACCESS;
            base_addr   <= mem_addr_i;
            store_data  <= mem_data_i;
            wd_q        <= wd_i;
            size_q      <= mem_size_i;
            is_signed_q <= !mem_op_i[1];
            is_store_q  <= mem_op_i[2];
            beat_cnt    <= '0;
            data_buf    <= '0;
            wd_cnt      <= '0;
          end
        end
        ACCESS: begin
          // Priority: flush, then ack (beats a simultaneous timeout), then timeout.
          if (flush_i) begin
            state <= IDLE;
          end else if (ram.ram_ack) begin
            if (!is_store_q) begin
              data_buf[{beat_cnt, 3'b000} +: 8] <= ram.ram_rdata;
            end
            wd_cnt <= '0;
            if (beat_cnt == last_beat) begin
              state <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 2'd1;
            end
          end else if (timeout_hit) begin
            state <= IDLE;
          end else if (TIMEOUT != 0) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    ram.ram_req   = 1'b0;
    ram.ram_wr    = 1'b0;
    ram.ram_addr  = '0;
    ram.ram_wdata = '0;
    wd_o          = '0;
    wreg_o        = 1'b0;
    wdata_o       = '0;
    stall_req     = 1'b0;
    err_o         = 1'b0;
    if (rst && !flush_i) begin
      case (state)
        IDLE: begin
          if (valid_i && !is_mem) begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end else if (start) begin
            stall_req = 1'b1;
          end
        end
        ACCESS: begin
          ram.ram_req   = 1'b1;
          ram.ram_wr    = is_store_q;
          ram.ram_addr  = base_addr + ADDR_W'(beat_cnt);
          ram.ram_wdata = store_data[{beat_cnt, 3'b000} +: 8];
          if (timeout_hit && !ram.ram_ack) begin
            err_o = 1'b1;
          end else begin
            stall_req = 1'b1;
          end
        end
        DONE: begin
          if (!is_store_q) begin
            wd_o    = wd_q;
            wreg_o  = 1'b1;
            wdata_o = load_data;
          end
        end
        default: begin
          stall_req = 1'b0;
        end
      endcase
    end
  end

endmodule
